// File: rtl/parity_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_rx
// Purpose  : Receive end of the XOR-parity serial link. Deserialises frames of
//            start(0), DATA_W data bits LSB first, parity bit, stop(1) from a
//            single idle-high line. It checks parity and framing, then
//            presents each word with a one-cycle valid pulse and error flags.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous active-high reset
//            rx         - serial line (asynchronous to clk, idle 1)
//            data_out   - last received word, held until next frame completes
//            valid      - 1-cycle pulse when data_out and the flags update
//            parity_err - parity mismatch for the flagged word
//            frame_err  - stop bit sampled 0 for the flagged word
//            busy       - high whenever the receiver is not idle
// Config   : PARITY_SERIAL_RX_ODD_EN defined   -> odd parity
//            PARITY_SERIAL_RX_ODD_EN undefined -> even parity (default)
// Revision : 1.0 - initial release
// ============================================================================
module parity_serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    // The start bit is re-checked at mid-bit. Every later sample then falls
    // one full bit period after the previous one.
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);

`ifdef PARITY_SERIAL_RX_ODD_EN
    localparam logic c_EXP = 1'b1;
`else
    localparam logic c_EXP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic [c_CNT_W-1:0]  r_cyc_cnt;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_pbit;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_valid;
    logic                r_parity_err;
    logic                r_frame_err;

    // Two-flop synchroniser. Both flops reset to the idle level so that
    // reset cannot produce a false start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cyc_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_pbit       <= 1'b0;
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_cyc_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_cyc_cnt == c_CNT_HALF) begin
                        r_cyc_cnt <= '0;
                        r_bit_idx <= '0;
                        // A line already back high at mid-bit was a glitch.
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cyc_cnt == c_CNT_LAST) begin
                        r_cyc_cnt          <= '0;
                        r_shreg[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cyc_cnt == c_CNT_LAST) begin
                        r_cyc_cnt <= '0;
                        r_pbit    <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cyc_cnt == c_CNT_LAST) begin
                        r_cyc_cnt    <= '0;
                        // The results register on the stop-sample edge and
                        // are visible in the next cycle. The FSM is already
                        // idle then, so a start bit that directly follows
                        // the stop bit is still caught.
                        r_data_out   <= r_shreg;
                        r_valid      <= 1'b1;
                        r_parity_err <= ((^r_shreg) ^ r_pbit) != c_EXP;
                        r_frame_err  <= ~r_rx_s;
                        r_state      <= r_rx_s ? S_IDLE : S_RECOVER;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_RECOVER: begin
                    // A line held low must return high before a new start
                    // edge is accepted.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_serial_rx
// Purpose  : Directed self-checking bench for parity_serial_rx with
//            DATA_W=8 and CLKS_PER_BIT=4. Frames are driven bit-accurately
//            and every valid pulse is captured by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_serial_rx;

    localparam int c_CPB = 4;

`ifdef PARITY_SERIAL_RX_ODD_EN
    localparam bit c_ODD = 1'b1;
`else
    localparam bit c_ODD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vcnt     = 0;

    logic [7:0] cap_data [0:15];
    logic       cap_perr [0:15];
    logic       cap_ferr [0:15];
    int         cap_cyc  [0:15];

    parity_serial_rx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (c_CPB)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid pulse away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            cap_data[vcnt % 16] = data_out;
            cap_perr[vcnt % 16] = parity_err;
            cap_ferr[vcnt % 16] = frame_err;
            cap_cyc[vcnt % 16]  = cyc;
            vcnt = vcnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (c_CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base;
    int li;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_data", 32'(data_out), 32'h0);
        check_val("rst_valid", 32'(valid), 32'h0);
        check_val("rst_perr", 32'(parity_err), 32'h0);
        check_val("rst_ferr", 32'(frame_err), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle_cycles(4);

        // Good frame 0xA5 (four ones, even parity bit 0).
        base = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_cycles(8);
        li = (vcnt - 1) % 16;
        check_val("a5_count", 32'(vcnt - base), 32'd1);
        check_val("a5_data", 32'(cap_data[li]), 32'hA5);
        check_val("a5_perr", 32'(cap_perr[li]), c_ODD ? 32'd1 : 32'd0);
        check_val("a5_ferr", 32'(cap_ferr[li]), 32'd0);
        check_val("a5_busy", 32'(busy), 32'd0);

        // 0x01 with parity bit 0: one set bit in total.
        base = vcnt;
        send_frame(8'h01, 1'b0, 1'b1);
        idle_cycles(8);
        li = (vcnt - 1) % 16;
        check_val("p01_count", 32'(vcnt - base), 32'd1);
        check_val("p01_data", 32'(cap_data[li]), 32'h01);
        check_val("p01_perr", 32'(cap_perr[li]), c_ODD ? 32'd0 : 32'd1);

        // 0x3C with a bad stop bit, then the line is held low for 20 cycles.
        base = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        li = (vcnt - 1) % 16;
        check_val("fe_count", 32'(vcnt - base), 32'd1);
        check_val("fe_data", 32'(cap_data[li]), 32'h3C);
        check_val("fe_perr", 32'(cap_perr[li]), c_ODD ? 32'd1 : 32'd0);
        check_val("fe_ferr", 32'(cap_ferr[li]), 32'd1);
        check_val("fe_busy_low", 32'(busy), 32'd1);
        idle_cycles(8);
        check_val("fe_busy_rel", 32'(busy), 32'd0);
        check_val("fe_no_extra", 32'(vcnt - base), 32'd1);

        // A one-cycle glitch must not produce a frame.
        base = vcnt;
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle_cycles(6);
        check_val("gl_busy", 32'(busy), 32'd0);
        check_val("gl_count", 32'(vcnt - base), 32'd0);

        // Reset in the middle of the DATA phase of 0x77.
        base = vcnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("mr_data", 32'(data_out), 32'h0);
        check_val("mr_valid", 32'(valid), 32'h0);
        check_val("mr_ferr", 32'(frame_err), 32'h0);
        check_val("mr_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(4);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle_cycles(8);
        li = (vcnt - 1) % 16;
        check_val("mr_count", 32'(vcnt - base), 32'd1);
        check_val("mr5a_data", 32'(cap_data[li]), 32'h5A);
        check_val("mr5a_perr", 32'(cap_perr[li]), c_ODD ? 32'd1 : 32'd0);
        check_val("mr5a_ferr", 32'(cap_ferr[li]), 32'd0);

        // Back-to-back frames 0x00 and 0xFF with no idle gap.
        base = vcnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_cycles(8);
        check_val("bb_count", 32'(vcnt - base), 32'd2);
        check_val("bb_gap", 32'(cap_cyc[(base + 1) % 16] - cap_cyc[base % 16]), 32'd44);
        check_val("bb0_data", 32'(cap_data[base % 16]), 32'h00);
        check_val("bb0_perr", 32'(cap_perr[base % 16]), c_ODD ? 32'd1 : 32'd0);
        check_val("bb0_ferr", 32'(cap_ferr[base % 16]), 32'd0);
        check_val("bb1_data", 32'(cap_data[(base + 1) % 16]), 32'hFF);
        check_val("bb1_perr", 32'(cap_perr[(base + 1) % 16]), c_ODD ? 32'd1 : 32'd0);
        check_val("bb1_ferr", 32'(cap_ferr[(base + 1) % 16]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
